// File: rtl/pipe_issue_sched.sv
// ---------------------------------------------------------------------------
// pipe_issue_sched
//
// Two-requester issue scheduler for the 4-stage register/memory pipeline.
// Requesters A and B each offer one {func, rs1, rs2, rd, addr} instruction
// over a valid/ready handshake. A round-robin pointer picks between them
// when both can go. A shift scoreboard of in-flight destination registers
// holds back any instruction that reads a register still being written.
// The winner's fields are registered onto the iss_* outputs one edge later.
//
// Parameters
//   WB_LAT  cycles from issue until a producer's write is visible to a newly
//           issued reader (scoreboard depth, 1..8)
//   RW      register index width
//   AW      memory address width
//   FW      func code width
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   a_valid / a_ready            requester A handshake (ready = grant)
//   a_func/rs1/rs2/rd/addr       requester A instruction fields
//   b_*                          same for requester B
//   iss_valid                    issue fields carry a real instruction
//   iss_func/rs1/rs2/rd/addr     registered issue fields
//   iss_src                      0 = from A, 1 = from B
//   busy                         any scoreboard entry valid
//   stat_issue, stat_stall       saturating counters, only when the
//                                PIPE_ISSUE_STATS_EN macro is defined
//
// Round-robin pointer
//   state | meaning
//   PTR_A | A wins when both requesters are eligible
//   PTR_B | B wins when both requesters are eligible
// ---------------------------------------------------------------------------
module pipe_issue_sched #(
    parameter int WB_LAT = 3,
    parameter int RW     = 4,
    parameter int AW     = 8,
    parameter int FW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic [FW-1:0] a_func,
    input  logic [RW-1:0] a_rs1,
    input  logic [RW-1:0] a_rs2,
    input  logic [RW-1:0] a_rd,
    input  logic [AW-1:0] a_addr,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic [FW-1:0] b_func,
    input  logic [RW-1:0] b_rs1,
    input  logic [RW-1:0] b_rs2,
    input  logic [RW-1:0] b_rd,
    input  logic [AW-1:0] b_addr,

    output logic          iss_valid,
    output logic [FW-1:0] iss_func,
    output logic [RW-1:0] iss_rs1,
    output logic [RW-1:0] iss_rs2,
    output logic [RW-1:0] iss_rd,
    output logic [AW-1:0] iss_addr,
    output logic          iss_src,
    output logic          busy
`ifdef PIPE_ISSUE_STATS_EN
    ,
    output logic [15:0]   stat_issue,
    output logic [15:0]   stat_stall
`endif
);

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    ptr_e ptr_q, ptr_d;

    // Scoreboard: entry 0 is the instruction issued at the previous edge.
    logic [WB_LAT-1:0] sb_v_q, sb_v_d;
    logic [RW-1:0]     sb_rd_q [WB_LAT];
    logic [RW-1:0]     sb_rd_d [WB_LAT];

    logic          iss_valid_q, iss_valid_d;
    logic [FW-1:0] iss_func_q,  iss_func_d;
    logic [RW-1:0] iss_rs1_q,   iss_rs1_d;
    logic [RW-1:0] iss_rs2_q,   iss_rs2_d;
    logic [RW-1:0] iss_rd_q,    iss_rd_d;
    logic [AW-1:0] iss_addr_q,  iss_addr_d;
    logic          iss_src_q,   iss_src_d;

    logic haz_a, haz_b;
    logic elig_a, elig_b;
    logic gnt_a, gnt_b, gnt_any;

    // Hazard detection. The oldest entry is excluded: its regbank write lands
    // in the same cycle a reader granted now reaches the read stage, so a
    // producer issued at edge k releases its consumer for edge k+WB_LAT.
    always_comb begin
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = 0; i < WB_LAT - 1; i++) begin
            if (sb_v_q[i]) begin
                if ((a_rs1 == sb_rd_q[i]) || (a_rs2 == sb_rd_q[i])) begin
                    haz_a = 1'b1;
                end
                if ((b_rs1 == sb_rd_q[i]) || (b_rs2 == sb_rd_q[i])) begin
                    haz_b = 1'b1;
                end
            end
        end
    end

    // Arbitration. rst_n gates eligibility so nothing is accepted while the
    // block is held in reset.
    always_comb begin
        elig_a  = rst_n & a_valid & ~haz_a;
        elig_b  = rst_n & b_valid & ~haz_b;
        gnt_a   = elig_a & (~elig_b | (ptr_q == PTR_A));
        gnt_b   = elig_b & (~elig_a | (ptr_q == PTR_B));
        gnt_any = gnt_a | gnt_b;

        ptr_d = ptr_q;
        if (gnt_a) begin
            ptr_d = PTR_B;
        end else if (gnt_b) begin
            ptr_d = PTR_A;
        end
    end

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    // Issue register and scoreboard next state.
    always_comb begin
        iss_valid_d = gnt_any;
        iss_func_d  = iss_func_q;
        iss_rs1_d   = iss_rs1_q;
        iss_rs2_d   = iss_rs2_q;
        iss_rd_d    = iss_rd_q;
        iss_addr_d  = iss_addr_q;
        iss_src_d   = iss_src_q;

        if (gnt_a) begin
            iss_func_d = a_func;
            iss_rs1_d  = a_rs1;
            iss_rs2_d  = a_rs2;
            iss_rd_d   = a_rd;
            iss_addr_d = a_addr;
            iss_src_d  = 1'b0;
        end else if (gnt_b) begin
            iss_func_d = b_func;
            iss_rs1_d  = b_rs1;
            iss_rs2_d  = b_rs2;
            iss_rd_d   = b_rd;
            iss_addr_d = b_addr;
            iss_src_d  = 1'b1;
        end

        sb_v_d     = '0;
        sb_v_d[0]  = gnt_any;
        sb_rd_d[0] = gnt_a ? a_rd : b_rd;
        for (int i = 1; i < WB_LAT; i++) begin
            sb_v_d[i]  = sb_v_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= PTR_A;
            sb_v_q      <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                sb_rd_q[i] <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_func_q  <= '0;
            iss_rs1_q   <= '0;
            iss_rs2_q   <= '0;
            iss_rd_q    <= '0;
            iss_addr_q  <= '0;
            iss_src_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            sb_v_q      <= sb_v_d;
            for (int i = 0; i < WB_LAT; i++) begin
                sb_rd_q[i] <= sb_rd_d[i];
            end
            iss_valid_q <= iss_valid_d;
            iss_func_q  <= iss_func_d;
            iss_rs1_q   <= iss_rs1_d;
            iss_rs2_q   <= iss_rs2_d;
            iss_rd_q    <= iss_rd_d;
            iss_addr_q  <= iss_addr_d;
            iss_src_q   <= iss_src_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_func  = iss_func_q;
    assign iss_rs1   = iss_rs1_q;
    assign iss_rs2   = iss_rs2_q;
    assign iss_rd    = iss_rd_q;
    assign iss_addr  = iss_addr_q;
    assign iss_src   = iss_src_q;
    assign busy      = |sb_v_q;

`ifdef PIPE_ISSUE_STATS_EN
    logic [15:0] stat_issue_q, stat_issue_d;
    logic [15:0] stat_stall_q, stat_stall_d;
    logic        stall_evt;

    // A hazarded requester can never be granted, so any valid hazarded
    // requester counts as a stalled cycle.
    always_comb begin
        stall_evt    = (a_valid & haz_a) | (b_valid & haz_b);
        stat_issue_d = stat_issue_q;
        stat_stall_d = stat_stall_q;
        if (gnt_any && (stat_issue_q != 16'hFFFF)) begin
            stat_issue_d = stat_issue_q + 16'd1;
        end
        if (stall_evt && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_issue_q <= stat_issue_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_pipe_issue_sched.sv
module tb_pipe_issue_sched;

    localparam int WB_LAT = 3;
    localparam int RW     = 4;
    localparam int AW     = 8;
    localparam int FW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [FW-1:0] a_func, b_func;
    logic [RW-1:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [AW-1:0] a_addr, b_addr;
    logic          iss_valid, iss_src, busy;
    logic [FW-1:0] iss_func;
    logic [RW-1:0] iss_rs1, iss_rs2, iss_rd;
    logic [AW-1:0] iss_addr;
`ifdef PIPE_ISSUE_STATS_EN
    logic [15:0]   stat_issue, stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    pipe_issue_sched #(.WB_LAT(WB_LAT), .RW(RW), .AW(AW), .FW(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_func    (a_func),
        .a_rs1     (a_rs1),
        .a_rs2     (a_rs2),
        .a_rd      (a_rd),
        .a_addr    (a_addr),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_func    (b_func),
        .b_rs1     (b_rs1),
        .b_rs2     (b_rs2),
        .b_rd      (b_rd),
        .b_addr    (b_addr),
        .iss_valid (iss_valid),
        .iss_func  (iss_func),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_addr  (iss_addr),
        .iss_src   (iss_src),
        .busy      (busy)
`ifdef PIPE_ISSUE_STATS_EN
        ,
        .stat_issue(stat_issue),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [FW-1:0] f, input logic [RW-1:0] r1,
                           input logic [RW-1:0] r2, input logic [RW-1:0] d, input logic [AW-1:0] ad);
        a_valid = v; a_func = f; a_rs1 = r1; a_rs2 = r2; a_rd = d; a_addr = ad;
    endtask

    task automatic drive_b(input logic v, input logic [FW-1:0] f, input logic [RW-1:0] r1,
                           input logic [RW-1:0] r2, input logic [RW-1:0] d, input logic [AW-1:0] ad);
        b_valid = v; b_func = f; b_rs1 = r1; b_rs2 = r2; b_rd = d; b_addr = ad;
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;

        // Reset with both requesters valid: nothing accepted.
        drive_a(1, 4'h1, 4'd1, 4'd2, 4'd3, 8'h11);
        drive_b(1, 4'h2, 4'd4, 4'd5, 4'd6, 8'h22);
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iss_rd", iss_rd, 0);
        chk("rst_iss_func", iss_func, 0);
        chk("rst_iss_addr", iss_addr, 0);
        chk("rst_iss_src", iss_src, 0);
        tick();
        chk("rst_hold_iss_valid", iss_valid, 0);
        chk("rst_hold_a_ready", a_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;

        // Fair arbitration A,B,A,B.
        chk("arb0_a_ready", a_ready, 1);
        chk("arb0_b_ready", b_ready, 0);
        tick();
        chk("arb1_valid", iss_valid, 1);
        chk("arb1_src", iss_src, 0);
        chk("arb1_rd", iss_rd, 3);
        chk("arb1_b_ready", b_ready, 1);
        chk("arb1_a_ready", a_ready, 0);
        tick();
        chk("arb2_src", iss_src, 1);
        chk("arb2_rd", iss_rd, 6);
        chk("arb2_addr", iss_addr, 8'h22);
        chk("arb2_a_ready", a_ready, 1);
        tick();
        chk("arb3_src", iss_src, 0);
        chk("arb3_addr", iss_addr, 8'h11);
        tick();
        chk("arb4_src", iss_src, 1);
        chk("arb4_func", iss_func, 2);
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        tick();
        chk("idle_iss_valid", iss_valid, 0);
        chk("idle_func_hold", iss_func, 2);
        chk("busy_lat1", busy, 1);
        tick();
        chk("busy_lat2", busy, 1);
        tick();
        chk("busy_fall", busy, 0);

        // Independent stream on A.
        drive_a(1, 4'h0, 4'd3, 4'd5, 4'd10, 8'h40);
        #1;
        chk("add_a_ready", a_ready, 1);
        tick();
        chk("add_valid", iss_valid, 1);
        chk("add_rd", iss_rd, 10);
        chk("add_src", iss_src, 0);
        chk("add_addr", iss_addr, 8'h40);
        drive_a(1, 4'h2, 4'd3, 4'd8, 4'd12, 8'h41);
        #1;
        chk("mul_a_ready", a_ready, 1);
        tick();
        chk("mul_valid", iss_valid, 1);
        chk("mul_rd", iss_rd, 12);
        chk("mul_func", iss_func, 2);

        // Fill the scoreboard, then reset mid-stream.
        drive_a(1, 4'h5, 4'd3, 4'd5, 4'd14, 8'h42);
        tick();
        tick();
        tick();
        chk("full_busy", busy, 1);
        chk("full_rd", iss_rd, 14);
        rst_n = 1'b0;
        #1;
        chk("mrst_iss_valid", iss_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rd", iss_rd, 0);
        chk("mrst_addr", iss_addr, 0);
        chk("mrst_func", iss_func, 0);
        chk("mrst_a_ready", a_ready, 0);
        drive_a(1, 4'h0, 4'd14, 4'd2, 4'd10, 8'h50);
        #1;
        chk("mrst_a_ready2", a_ready, 0);
        tick();
        chk("mrst_hold_valid", iss_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_no_stall", a_ready, 1);

        // RAW stall: ADD r10 at edge k, SUB reads r10, issues at k+3.
        tick();
        chk("raw_prod_rd", iss_rd, 10);
        chk("raw_prod_valid", iss_valid, 1);
        drive_a(1, 4'h1, 4'd10, 4'd4, 4'd11, 8'h51);
        #1;
        chk("raw_stall1_ready", a_ready, 0);
        tick();
        chk("raw_k1_valid", iss_valid, 0);
        chk("raw_stall2_ready", a_ready, 0);
        tick();
        chk("raw_k2_valid", iss_valid, 0);
        chk("raw_release_ready", a_ready, 1);
        tick();
        chk("raw_k3_valid", iss_valid, 1);
        chk("raw_k3_rd", iss_rd, 11);
        chk("raw_k3_func", iss_func, 1);
`ifdef PIPE_ISSUE_STATS_EN
        chk("stat_issue_raw", stat_issue, 2);
        chk("stat_stall_raw", stat_stall, 2);
`endif

        // Bypass: A hazarded on r10, B independent goes at once.
        drive_a(1, 4'h0, 4'd1, 4'd2, 4'd10, 8'h60);
        #1;
        chk("byp_prod_ready", a_ready, 1);
        tick();
        chk("byp_prod_rd", iss_rd, 10);
        drive_a(1, 4'h0, 4'd10, 4'd0, 4'd9, 8'h61);
        drive_b(1, 4'h3, 4'd7, 4'd3, 4'd13, 8'h62);
        #1;
        chk("byp_a_ready", a_ready, 0);
        chk("byp_b_ready", b_ready, 1);
        tick();
        chk("byp_b_src", iss_src, 1);
        chk("byp_b_rd", iss_rd, 13);
        chk("byp_b_addr", iss_addr, 8'h62);
        drive_b(0, 0, 0, 0, 0, 0);
        #1;
        chk("byp_a_still", a_ready, 0);
        tick();
        chk("byp_gap_valid", iss_valid, 0);
        chk("byp_a_release", a_ready, 1);
        tick();
        chk("byp_a_src", iss_src, 0);
        chk("byp_a_rd", iss_rd, 9);
`ifdef PIPE_ISSUE_STATS_EN
        chk("stat_issue_byp", stat_issue, 5);
        chk("stat_stall_byp", stat_stall, 4);
`endif

        // Both requesters read the same in-flight register (rs1 on A, rs2 on B).
        drive_a(1, 4'h0, 4'd1, 4'd2, 4'd7, 8'h70);
        #1;
        chk("dual_prod_ready", a_ready, 1);
        tick();
        chk("dual_prod_rd", iss_rd, 7);
        drive_a(1, 4'h0, 4'd7, 4'd3, 4'd1, 8'h71);
        drive_b(1, 4'h0, 4'd2, 4'd7, 4'd2, 8'h72);
        #1;
        chk("dual_a_stall1", a_ready, 0);
        chk("dual_b_stall1", b_ready, 0);
        tick();
        chk("dual_k1_valid", iss_valid, 0);
        chk("dual_a_stall2", a_ready, 0);
        chk("dual_b_stall2", b_ready, 0);
        tick();
        chk("dual_k2_valid", iss_valid, 0);
        chk("dual_ptr_b_ready", b_ready, 1);
        chk("dual_ptr_a_ready", a_ready, 0);
        tick();
        chk("dual_b_src", iss_src, 1);
        chk("dual_b_rd", iss_rd, 2);
        chk("dual_a_ready", a_ready, 1);
        chk("dual_b_self_haz", b_ready, 0);
        tick();
        chk("dual_a_src", iss_src, 0);
        chk("dual_a_rd", iss_rd, 1);
        chk("dual_a_addr", iss_addr, 8'h71);
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        tick();
        chk("end_idle_valid", iss_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
